pdo_unpad_serializer: RTL
=========================

PDO_UNPAD_SERIALIZER -- requirements
Module: pdo_unpad_serializer

Interface
REQ-001 The block SHALL take parameter BUSW, default 32, output bus width in bits.
REQ-002 The block SHALL take parameter CNTW, default 2, word-counter width (log2 of 128/BUSW).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 blk_data  input  128  result block; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-006 blk_seglen  input  4  valid byte count when blk_full=0 (0..15).
REQ-007 blk_full  input  1  all 16 bytes valid; blk_seglen ignored.
REQ-008 blk_last  input  1  block is the final segment of the message.
REQ-009 blk_valid  input  1  block offered.
REQ-010 blk_ready  output  1  block accepted when blk_valid and blk_ready are both high.
REQ-011 do_data  output  BUSW  output word; bytes MSB-first.
REQ-012 do_valid  output  1  do_data valid.
REQ-013 do_ready  input  1  downstream accepts word.
REQ-014 do_last  output  1  final word of message.
REQ-015 busy  output  1  high while in SEND.

Function
REQ-016 The FSM SHALL have states IDLE and SEND only.
REQ-017 In IDLE, blk_ready SHALL be 1 and do_valid 0; in SEND, blk_ready SHALL be 0 and do_valid 1.
REQ-018 On block acceptance, the block SHALL register blk_data, blk_last, and nbytes = blk_full ? 16 : blk_seglen.
REQ-019 nwords SHALL be ceil(nbytes*8/BUSW); with BUSW=32: 16->4, 1..4->1, 5..8->2, 9..12->3, 13..15->4.
REQ-020 If nwords=0 on acceptance, the block SHALL consume the block, stay in IDLE, and emit nothing.
REQ-021 If nwords>0 on acceptance, the block SHALL enter SEND with cnt=0; do_valid SHALL rise on the cycle after acceptance (latency 1).
REQ-022 do_data SHALL be bytes cnt*BUSW/8 .. cnt*BUSW/8+BUSW/8-1 of the registered block.
REQ-023 Each byte index >= nbytes SHALL be driven 8'h00 on do_data.
REQ-024 do_data, do_valid and do_last SHALL be driven from registers only, with no combinational path from any input.
REQ-025 do_data and do_last SHALL hold stable while do_valid=1 and do_ready=0.
REQ-026 On do_valid&do_ready with cnt=nwords-1, the FSM SHALL return to IDLE; otherwise cnt SHALL increment.
REQ-027 do_last SHALL equal registered blk_last AND (cnt = nwords-1).
REQ-028 Throughput: a new block SHALL be accepted no earlier than the cycle after the final word handshake; the block SHALL add no bubble beyond that IDLE cycle.
REQ-029 cnt SHALL never exceed nwords-1 and SHALL not wrap within a block.

Reset
REQ-030 rst_n=0 SHALL force, asynchronously, state=IDLE, cnt=0, do_valid=0, do_last=0, do_data=0, busy=0, and all block registers to 0.
REQ-031 Reset mid-SEND SHALL discard the pending block with no further words emitted.
REQ-032 After rst_n deasserts, blk_ready SHALL be 1 on the next rising edge.

Structure
REQ-033 BUSW, CNTW and block byte count (16) SHALL come from romulus_config_pkg.v.
REQ-034 The nbytes-to-16-bit-byte-mask decode SHALL live in sub-module byte_mask_gen, instantiated once.

Verification
REQ-035 Full block 00112233_44556677_8899AABB_CCDDEEFF, blk_full=1, blk_last=1, do_ready=1 -> 4 words 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles; do_last on the 4th only.
REQ-036 Same data, blk_full=0, seglen=6, blk_last=1 -> 2 words 00112233, 44550000; do_last on the 2nd.
REQ-037 seglen=0, blk_full=0 -> block consumed, do_valid never rises, blk_ready stays 1.
REQ-038 seglen=13, do_ready toggled 1/0 every cycle -> 4 words, last = CC000000; each word held stable during stall; do_last only when blk_last=1.
REQ-039 rst_n pulsed low during word 2 of a full block -> do_valid drops immediately; after release, a new block is accepted and output starts at cnt=0.
REQ-040 Back-to-back full blocks with blk_last=0 then 1 -> 8 words; exactly one IDLE cycle between blocks; do_last only on the 8th word.

Source files
------------

// File: rtl/romulus_config_pkg.sv
// romulus_config_pkg
// Shared configuration for the PDO unpad serializer:
//   CFG_BUSW  - default output bus width in bits
//   CFG_CNTW  - default word-counter width, log2(128/CFG_BUSW)
//   BLK_BYTES - bytes per result block
//   BLK_BITS  - bits per result block
//   NB_W      - width of a byte count 0..BLK_BYTES
//   state_e   - serializer FSM states
package romulus_config_pkg;

  localparam int CFG_BUSW  = 32;
  localparam int CFG_CNTW  = 2;
  localparam int BLK_BYTES = 16;
  localparam int BLK_BITS  = BLK_BYTES * 8;
  localparam int NB_W      = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/byte_mask_gen.sv
// byte_mask_gen
// Decodes a valid byte count into a per-byte keep mask for a result block.
// Ports:
//   nbytes - number of valid leading bytes (0..BLK_BYTES)
//   mask   - one bit per byte; bit BLK_BYTES-1 is byte 0 (the MSB-first byte),
//            bit 0 is byte BLK_BYTES-1
module byte_mask_gen
  import romulus_config_pkg::*;
(
  input  logic [NB_W-1:0]      nbytes,
  output logic [BLK_BYTES-1:0] mask
);

  for (genvar gi = 0; gi < BLK_BYTES; gi++) begin : g_mask
    // Byte gi survives only if it lies inside the valid prefix.
    assign mask[BLK_BYTES-1-gi] = (NB_W'(gi) < nbytes);
  end

endmodule

// File: rtl/pdo_unpad_serializer.sv
// pdo_unpad_serializer
// Accepts 128-bit result blocks, zeroes the bytes beyond the valid segment
// length and emits the block as BUSW-bit words, MSB-first, over a
// valid/ready stream. All stream outputs come straight from registers.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   blk_data/seglen/full/last     - offered block and its length/last flags
//   blk_valid / blk_ready         - block handshake (ready only in IDLE)
//   do_data / do_valid / do_last  - output word stream
//   do_ready                      - downstream accepts the current word
//   busy                          - high while a block is being sent
module pdo_unpad_serializer
  import romulus_config_pkg::*;
#(
  parameter int BUSW = CFG_BUSW,
  parameter int CNTW = CFG_CNTW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BLK_BITS-1:0] blk_data,
  input  logic [3:0]          blk_seglen,
  input  logic                blk_full,
  input  logic                blk_last,
  input  logic                blk_valid,
  output logic                blk_ready,
  output logic [BUSW-1:0]     do_data,
  output logic                do_valid,
  input  logic                do_ready,
  output logic                do_last,
  output logic                busy
);

  localparam int BPW    = BUSW / 8;
  localparam int NWORDS = BLK_BYTES / BPW;
  localparam int NWW    = CNTW + 1;

  state_e              state_q;
  logic [CNTW-1:0]     cnt_q;
  logic [CNTW-1:0]     cnt_d;
  logic [NWW-1:0]      nwords_q;
  logic [BLK_BITS-1:0] blk_q;
  logic                last_q;
  logic [BUSW-1:0]     do_data_q;
  logic                do_valid_q;
  logic                do_last_q;
  logic                busy_q;

  logic [NB_W-1:0]      nbytes_in;
  logic [NWW-1:0]       nwords_in;
  logic [BLK_BYTES-1:0] byte_mask;
  logic [BLK_BITS-1:0]  bit_mask;
  logic [BLK_BITS-1:0]  masked_in;
  logic [BUSW-1:0]      in_words  [NWORDS];
  logic [BUSW-1:0]      blk_words [NWORDS];
  logic                 final_word;

  assign nbytes_in = blk_full ? NB_W'(BLK_BYTES) : {1'b0, blk_seglen};
  assign nwords_in = NWW'((int'(nbytes_in) + BPW - 1) / BPW);

  byte_mask_gen u_byte_mask_gen (
    .nbytes (nbytes_in),
    .mask   (byte_mask)
  );

  for (genvar gi = 0; gi < BLK_BYTES; gi++) begin : g_bit_mask
    assign bit_mask[gi*8 +: 8] = {8{byte_mask[gi]}};
  end

  // Padding is stripped once at acceptance, so the stored block is already
  // zero beyond nbytes and words can be sliced from it directly.
  assign masked_in = blk_data & bit_mask;

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
    assign in_words[gi]  = masked_in[BLK_BITS-1-gi*BUSW -: BUSW];
    assign blk_words[gi] = blk_q[BLK_BITS-1-gi*BUSW -: BUSW];
  end

  assign cnt_d      = cnt_q + 1'b1;
  assign final_word = ({1'b0, cnt_q} == nwords_q - NWW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nwords_q   <= '0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      do_data_q  <= '0;
      do_valid_q <= 1'b0;
      do_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_valid) begin
            blk_q    <= masked_in;
            last_q   <= blk_last;
            nwords_q <= nwords_in;
            cnt_q    <= '0;
            // An empty segment is consumed silently.
            if (nwords_in != '0) begin
              state_q    <= ST_SEND;
              do_data_q  <= in_words[0];
              do_valid_q <= 1'b1;
              do_last_q  <= blk_last && (nwords_in == NWW'(1));
              busy_q     <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (do_ready) begin
            if (final_word) begin
              state_q    <= ST_IDLE;
              do_valid_q <= 1'b0;
              do_last_q  <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              cnt_q     <= cnt_d;
              do_data_q <= blk_words[cnt_d];
              do_last_q <= last_q && ({1'b0, cnt_d} == nwords_q - NWW'(1));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign blk_ready = (state_q == ST_IDLE);
  assign do_data   = do_data_q;
  assign do_valid  = do_valid_q;
  assign do_last   = do_last_q;
  assign busy      = busy_q;

endmodule
